mpw_wb_ctrl: RTL and testbench
==============================

# mpw_wb_ctrl

Parametrised Wishbone-controlled front end for the multi-project shuttle harness, placed between the Caravel pads/Wishbone bus and the design multiplexer. It synchronises design reset over a configurable depth and registers the design select. It lets firmware override the select, hold, reset and input pins that were previously pad-only. It also samples design outputs and raises an interrupt when masked bits change.

## Interface
- `N_IO`, 12, design input/output width
- `SEL_W`, 6, design-select width
- `SYNC_DEPTH`, 5, reset synchroniser length (≥2)
- `BASE_ADDR`, 32'h3000_0000, Wishbone window base; window is 256 bytes

- `wb_clk_i`  in  1  sole clock
- `wb_rst_i`  in  1  reset, asynchronous, active-high
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1  Wishbone strobe/cycle/write
- `wbs_sel_i`  in  4  byte lanes
- `wbs_adr_i`, `wbs_dat_i`  in  32  address, write data
- `wbs_ack_o`  out  1  acknowledge
- `wbs_dat_o`  out  32  read data
- `pad_in`  in  N_IO  pad design inputs
- `pad_sel`  in  SEL_W  pad design select
- `pad_hold`, `pad_reset`  in  1  pad hold-if-not-selected, pad reset (asynchronous to clock)
- `des_out`  in  N_IO  selected design outputs
- `des_in`  out  N_IO  inputs to design mux
- `des_sel`  out  SEL_W  registered design select
- `des_hold`, `des_reset`  out  1  hold, synchronised reset
- `irq`  out  1  change interrupt

## Operation
- Register map, word offsets from BASE_ADDR:
  - 0x00 CTRL: b0 OVR_EN, b1 SW_RESET, b2 SW_HOLD, b3 IRQ_EN.
  - 0x04 SEL: [SEL_W-1:0].
  - 0x08 DIN: [N_IO-1:0].
  - 0x0C DOUT: read-only `dout_q`.
  - 0x10 STATUS: b0 PEND (write-1-to-clear), b1 live `des_reset` (RO).
  - 0x14 MASK: [N_IO-1:0].
  - 0x18 CYCLES (see Configuration).
- Unmapped offsets read 0, writes ignored. Unused upper bits read 0.
- Writes honour `wbs_sel_i` per byte lane.
- Source mux: OVR_EN=1 selects SEL/DIN/SW_HOLD/SW_RESET. OVR_EN=0 selects `pad_sel`/`pad_in`/`pad_hold`/`pad_reset`.
- `des_in` and `des_hold` are combinational from the mux. `des_sel` is registered.
- Reset chain: `SYNC_DEPTH` flops, all preset to 1 by `wb_rst_i`. They shift in the muxed reset source each cycle. `des_reset` = last flop.
- Change detect: `dout_q` <= `des_out` every cycle; `dout_p` <= `dout_q`.
  - PEND sets when |((dout_q^dout_p)&MASK) and `des_reset`=0.
  - PEND is sticky.
- `irq` = PEND & IRQ_EN.
- Simultaneous PEND set and W1C: set wins.

## Timing
- Reset values:
  - `wbs_ack_o`=0, `wbs_dat_o`=0, `irq`=0.
  - All registers and PEND = 0; `des_sel`=0.
  - `des_reset`=1.
  - `des_in`/`des_hold` follow the pads, since OVR_EN=0.
- Wishbone handshake:
  - A request is stb&cyc&!ack with `wbs_adr_i[31:8]`==BASE_ADDR[31:8].
  - `wbs_ack_o` is a single-cycle pulse in the next cycle.
  - Back-to-back transactions therefore take ≥2 cycles each.
  - Addresses outside the window are never acked.
  - `wbs_dat_o` is registered and valid with ack; it is 0 otherwise.
  - A write takes effect at the same edge that raises ack.
- `des_sel` changes 1 cycle after its source changes (register write or pad).
- `des_reset` rises/falls exactly SYNC_DEPTH cycles after the muxed source rises/falls.
  - An assertion of `wb_rst_i` forces it to 1 immediately (asynchronous).
- PEND sets 2 cycles after a masked `des_out` change; `irq` follows combinationally.
- Toggling OVR_EN switches all sources at once. No intermediate glitch filtering is applied.
- `wb_rst_i` mid-transaction: ack is dropped and the write is lost.

## Configuration
- `MPW_CYCLE_COUNTER_EN` defined:
  - 0x18 is a 32-bit counter, cleared while `des_reset`=1, incremented each cycle otherwise.
  - Wraps 0xFFFF_FFFF→0.
  - Read-only.
- Undefined: no counter hardware; 0x18 reads 0.

## Test plan
- Assert and release `wb_rst_i`, pads idle with `pad_reset`=0:
  - During reset: `des_reset`=1, ack=0, `irq`=0.
  - `des_reset` falls on the 5th edge after release (SYNC_DEPTH=5).
- Write CTRL=0x1, SEL=0x2A, DIN=0xABC:
  - Each write acked in 1 cycle.
  - `des_sel`=0x2A one cycle later; `des_in`=0xABC regardless of `pad_in`.
  - Readback matches.
- Write DIN with `wbs_sel_i`=4'b0001 and data 0xFFFF_FFFF over DIN=0xABC → DIN reads 0xAFF.
- MASK=0x001, IRQ_EN=1, toggle `des_out[0]`:
  - PEND and `irq` rise 2 cycles later.
  - Toggling `des_out[1]` alone has no effect.
  - Writing STATUS=1 clears PEND; a coincident new change keeps PEND=1.
- Pulse `pad_reset` for 3 cycles with OVR_EN=0:
  - `des_reset` high for 3 cycles, starting 5 cycles later.
  - With OVR_EN=1, `pad_reset` is ignored.
- Access address BASE_ADDR+0x100 → no ack within 10 cycles.
- Access offset 0x18:
  - With `MPW_CYCLE_COUNTER_EN`, two reads N cycles apart differ by N.
  - Without it, reads return 0.

Source files
------------

// File: rtl/mpw_wb_if.sv
// Wishbone slave bus bundle for the MPW harness front end.
interface mpw_wb_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/mpw_wb_ctrl.sv
// Wishbone front end for the MPW design mux: select/reset/hold/input override,
// reset synchroniser, output change interrupt. Optional cycle counter: MPW_CYCLE_COUNTER_EN.
module mpw_wb_ctrl #(
    parameter int          N_IO       = 12,
    parameter int          SEL_W      = 6,
    parameter int          SYNC_DEPTH = 5,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    mpw_wb_if.slave          wb,
    input  logic [N_IO-1:0]  pad_in,
    input  logic [SEL_W-1:0] pad_sel,
    input  logic             pad_hold,
    input  logic             pad_reset,
    input  logic [N_IO-1:0]  des_out,
    output logic [N_IO-1:0]  des_in,
    output logic [SEL_W-1:0] des_sel,
    output logic             des_hold,
    output logic             des_reset,
    output logic             irq
);
    localparam logic [5:0] A_CTRL = 6'h00, A_SEL = 6'h01, A_DIN = 6'h02, A_DOUT = 6'h03,
                           A_STAT = 6'h04, A_MASK = 6'h05, A_CYC = 6'h06;

    logic [3:0]            ctrl_q;
    logic [SEL_W-1:0]      sel_q;
    logic [N_IO-1:0]       din_q, mask_q, dout_q, dout_p;
    logic                  pend_q;
    logic [SYNC_DEPTH-1:0] rst_sync;
    logic [31:0]           wm, rdata, cyc_val;
    logic [5:0]            word;
    logic                  req, wr, pend_set, pend_clr;
    logic                  ovr_en, irq_en;

    assign ovr_en = ctrl_q[0];
    assign irq_en = ctrl_q[3];
    assign word   = wb.wbs_adr_i[7:2];
    assign req    = wb.wbs_stb_i & wb.wbs_cyc_i & ~wb.wbs_ack_o &
                    (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr     = req & wb.wbs_we_i;
    assign wm     = {{8{wb.wbs_sel_i[3]}}, {8{wb.wbs_sel_i[2]}},
                     {8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}};

    logic unused_ok;
    assign unused_ok = ^{wb.wbs_adr_i[1:0], wb.wbs_dat_i, wm};

    // Source mux: firmware override or pads, switched together
    assign des_in   = ovr_en ? din_q     : pad_in;
    assign des_hold = ovr_en ? ctrl_q[2] : pad_hold;
    logic [SEL_W-1:0] src_sel;
    logic             src_reset;
    assign src_sel   = ovr_en ? sel_q     : pad_sel;
    assign src_reset = ovr_en ? ctrl_q[1] : pad_reset;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            des_sel  <= '0;
            rst_sync <= '1;
        end else begin
            des_sel  <= src_sel;
            rst_sync <= {rst_sync[SYNC_DEPTH-2:0], src_reset};
        end
    end
    assign des_reset = rst_sync[SYNC_DEPTH-1];

    // Change detect is suppressed while the design is held in reset
    assign pend_set = (|((dout_q ^ dout_p) & mask_q)) & ~des_reset;
    assign pend_clr = wr && word == A_STAT && wb.wbs_sel_i[0] && wb.wbs_dat_i[0];
    assign irq      = pend_q & irq_en;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ctrl_q <= '0;
            sel_q  <= '0;
            din_q  <= '0;
            mask_q <= '0;
            dout_q <= '0;
            dout_p <= '0;
            pend_q <= 1'b0;
        end else begin
            dout_q <= des_out;
            dout_p <= dout_q;
            pend_q <= pend_set | (pend_q & ~pend_clr);
            if (wr && word == A_CTRL)
                ctrl_q <= (ctrl_q & ~wm[3:0]) | (wb.wbs_dat_i[3:0] & wm[3:0]);
            if (wr && word == A_SEL)
                sel_q <= (sel_q & ~wm[SEL_W-1:0]) | (wb.wbs_dat_i[SEL_W-1:0] & wm[SEL_W-1:0]);
            if (wr && word == A_DIN)
                din_q <= (din_q & ~wm[N_IO-1:0]) | (wb.wbs_dat_i[N_IO-1:0] & wm[N_IO-1:0]);
            if (wr && word == A_MASK)
                mask_q <= (mask_q & ~wm[N_IO-1:0]) | (wb.wbs_dat_i[N_IO-1:0] & wm[N_IO-1:0]);
        end
    end

`ifdef MPW_CYCLE_COUNTER_EN
    logic [31:0] cyc_q;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)       cyc_q <= '0;
        else if (des_reset) cyc_q <= '0;
        else                cyc_q <= cyc_q + 32'd1;
    end
    assign cyc_val = cyc_q;
`else
    assign cyc_val = 32'd0;
`endif

    always_comb begin
        rdata = 32'd0;
        case (word)
            A_CTRL: rdata = {28'd0, ctrl_q};
            A_SEL:  rdata = 32'(sel_q);
            A_DIN:  rdata = 32'(din_q);
            A_DOUT: rdata = 32'(dout_q);
            A_STAT: rdata = {30'd0, des_reset, pend_q};
            A_MASK: rdata = 32'(mask_q);
            A_CYC:  rdata = cyc_val;
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_dat_o <= '0;
        end else begin
            wb.wbs_ack_o <= req;
            wb.wbs_dat_o <= (req && !wb.wbs_we_i) ? rdata : 32'd0;
        end
    end
endmodule

// File: tb/tb_mpw_wb_ctrl.sv
// Directed bench for mpw_wb_ctrl with hand-computed expectations.
module tb_mpw_wb_ctrl;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] pad_in, des_out, des_in;
    logic [5:0]  pad_sel, des_sel;
    logic        pad_hold, pad_reset, des_hold, des_reset, irq;
    int          tests = 0, fails = 0;
    logic [31:0] rd, rd2;

    mpw_wb_if wb ();

    mpw_wb_ctrl dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(wb.slave),
        .pad_in(pad_in), .pad_sel(pad_sel), .pad_hold(pad_hold), .pad_reset(pad_reset),
        .des_out(des_out), .des_in(des_in), .des_sel(des_sel), .des_hold(des_hold),
        .des_reset(des_reset), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = '0;   wb.wbs_dat_i = '0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b1;
        wb.wbs_sel_i = sel;  wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;
        tick();
        check("wr_ack", {31'd0, wb.wbs_ack_o}, 32'd1);
        bus_idle();
        tick();
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
        wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = adr;
        tick();
        check("rd_ack", {31'd0, wb.wbs_ack_o}, 32'd1);
        d = wb.wbs_dat_o;
        bus_idle();
        tick();
    endtask

    initial begin
        rst = 1'b1; bus_idle();
        pad_in = 12'h555; pad_sel = 6'h15; pad_hold = 1'b1; pad_reset = 1'b0; des_out = '0;
        repeat (3) tick();
        check("rst_des_reset", {31'd0, des_reset}, 32'd1);
        check("rst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
        check("rst_dat", wb.wbs_dat_o, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_des_sel", {26'd0, des_sel}, 32'd0);
        check("rst_des_in", {20'd0, des_in}, 32'h555);
        check("rst_des_hold", {31'd0, des_hold}, 32'd1);

        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("sync_rel_%0d", i), {31'd0, des_reset}, (i < 5) ? 32'd1 : 32'd0);
            if (i == 1) check("pad_sel_1cyc", {26'd0, des_sel}, 32'h15);
        end

        // Override path
        wb_write(BASE + 32'h00, 32'h1, 4'hF);
        check("ovr_hold", {31'd0, des_hold}, 32'd0);
        wb_write(BASE + 32'h04, 32'h2A, 4'hF);
        check("sw_sel", {26'd0, des_sel}, 32'h2A);
        wb_write(BASE + 32'h08, 32'hABC, 4'hF);
        check("sw_din", {20'd0, des_in}, 32'hABC);
        pad_in = 12'h0F0;
        #1;
        check("sw_din_pad_ign", {20'd0, des_in}, 32'hABC);
        wb_read(BASE + 32'h00, rd); check("rb_ctrl", rd, 32'h1);
        wb_read(BASE + 32'h04, rd); check("rb_sel", rd, 32'h2A);
        wb_read(BASE + 32'h08, rd); check("rb_din", rd, 32'hABC);
        wb_write(BASE + 32'h08, 32'hFFFF_FFFF, 4'b0001);
        wb_read(BASE + 32'h08, rd); check("din_lane0", rd, 32'hAFF);
        check("din_lane0_out", {20'd0, des_in}, 32'hAFF);
        wb_write(BASE + 32'h04, 32'hFFFF_FFFF, 4'hF);
        wb_read(BASE + 32'h04, rd); check("sel_upper0", rd, 32'h3F);
        wb_read(BASE + 32'h1C, rd); check("unmapped", rd, 32'h0);

        // Change detect
        wb_write(BASE + 32'h14, 32'h001, 4'hF);
        wb_write(BASE + 32'h00, 32'h9, 4'hF);
        wb_read(BASE + 32'h10, rd); check("stat_idle", rd, 32'h0);
        des_out = 12'h001;
        tick(); check("irq_1cyc", {31'd0, irq}, 32'd0);
        tick(); check("irq_2cyc", {31'd0, irq}, 32'd1);
        wb_read(BASE + 32'h0C, rd); check("dout_rd", rd, 32'h001);
        wb_read(BASE + 32'h10, rd); check("stat_pend", rd, 32'h1);
        wb_write(BASE + 32'h10, 32'h1, 4'hF);
        check("w1c_irq", {31'd0, irq}, 32'd0);
        des_out = 12'h003;
        repeat (3) tick();
        check("unmasked_irq", {31'd0, irq}, 32'd0);
        des_out = 12'h002;
        tick();
        wb_write(BASE + 32'h10, 32'h1, 4'hF);
        check("set_wins_irq", {31'd0, irq}, 32'd1);
        wb_read(BASE + 32'h10, rd); check("set_wins_stat", rd, 32'h1);
        wb_write(BASE + 32'h10, 32'h1, 4'hF);
        wb_read(BASE + 32'h10, rd); check("clr_stat", rd, 32'h0);

        // Pad reset path
        wb_write(BASE + 32'h00, 32'h0, 4'hF);
        check("pad_din", {20'd0, des_in}, 32'h0F0);
        check("pad_hold", {31'd0, des_hold}, 32'd1);
        check("pad_sel", {26'd0, des_sel}, 32'h15);
        pad_reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("pad_rst_%0d", i), {31'd0, des_reset},
                  (i >= 5 && i <= 7) ? 32'd1 : 32'd0);
            if (i == 3) pad_reset = 1'b0;
        end
        wb_write(BASE + 32'h00, 32'h1, 4'hF);
        pad_reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("pad_rst_ign_%0d", i), {31'd0, des_reset}, 32'd0);
        end
        pad_reset = 1'b0;

        // Out-of-window access
        wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = BASE + 32'h100;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("oow_noack_%0d", i), {31'd0, wb.wbs_ack_o}, 32'd0);
        end
        bus_idle();
        tick();

`ifdef MPW_CYCLE_COUNTER_EN
        wb_read(BASE + 32'h18, rd);
        repeat (5) tick();
        wb_read(BASE + 32'h18, rd2);
        check("cyc_diff", rd2 - rd, 32'd7);
`else
        wb_read(BASE + 32'h18, rd); check("cyc_absent", rd, 32'h0);
`endif

        // Asynchronous reset forces des_reset immediately and clears registers
        rst = 1'b1;
        #1;
        check("async_des_reset", {31'd0, des_reset}, 32'd1);
        check("async_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        wb_read(BASE + 32'h04, rd); check("post_rst_sel", rd, 32'h0);
        wb_read(BASE + 32'h10, rd); check("post_rst_stat", rd, 32'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
